// File: rtl/cache_fill_arbiter.sv
// cache_fill_arbiter
//   Miss handler sitting between the I-cache, the D-cache and a single-port
//   main memory. It arbitrates block fills and write-through stores, streams
//   the returned fill words into the requesting cache's data array, and
//   writes that cache's tag together with the last word. A cache keeps its
//   miss (and so its stall) asserted until it sees its tag write.
//
//   Optional feature macro: CRITICAL_WORD_FIRST_EN
//     When defined, a fill starts at the missed word and wraps around the
//     block. The extra outputs i_crit_valid/d_crit_valid pulse with the first
//     fill write so the stalled stage may restart early.
//     When undefined, a fill runs in ascending order from the block base.
//
// Parameters
//   BLOCK_WORDS  16-bit words per block (power of 2, 2..16)
//   ADDR_W       byte address width
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   i_miss, i_miss_addr         I-cache miss request / byte address
//   d_miss, d_miss_addr         D-cache miss request / byte address
//   d_wr, d_wr_addr, d_wr_data  write-through store request (held until ack)
//   d_wr_ack                    store issued to memory this cycle
//   mem_en, mem_wr, mem_addr,
//   mem_wdata                   memory request (one per cycle)
//   mem_rdata, mem_rvalid       in-order read return, fixed latency >= 1
//   fill_data, fill_word        registered return word and its block index
//   i_fill_we, d_fill_we        data-array write strobes
//   i_tag_we, d_tag_we          tag/valid write strobes (with last fill word)
//   i_crit_valid, d_crit_valid  first fill word written (feature build only)
//   i_busy, d_busy              fill in progress for that cache
module cache_fill_arbiter #(
  parameter int BLOCK_WORDS = 8,
  parameter int ADDR_W      = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_miss,
  input  logic [ADDR_W-1:0]              i_miss_addr,
  input  logic                           d_miss,
  input  logic [ADDR_W-1:0]              d_miss_addr,
  input  logic                           d_wr,
  input  logic [ADDR_W-1:0]              d_wr_addr,
  input  logic [15:0]                    d_wr_data,
  output logic                           d_wr_ack,
  output logic                           mem_en,
  output logic                           mem_wr,
  output logic [ADDR_W-1:0]              mem_addr,
  output logic [15:0]                    mem_wdata,
  input  logic [15:0]                    mem_rdata,
  input  logic                           mem_rvalid,
  output logic [15:0]                    fill_data,
  output logic [$clog2(BLOCK_WORDS)-1:0] fill_word,
  output logic                           i_fill_we,
  output logic                           d_fill_we,
  output logic                           i_tag_we,
  output logic                           d_tag_we,
`ifdef CRITICAL_WORD_FIRST_EN
  output logic                           i_crit_valid,
  output logic                           d_crit_valid,
`endif
  output logic                           i_busy,
  output logic                           d_busy
);

  localparam int WW = $clog2(BLOCK_WORDS);
  localparam logic [WW-1:0]     LAST     = WW'(BLOCK_WORDS - 1);
  // Byte-offset bits inside one block; cleared to form the block base.
  localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(2 * BLOCK_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WSTORE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic                r_owner_d;     // 1: fill serves the D-cache
  logic [ADDR_W-1:0]   r_base;
  logic [WW-1:0]       r_issue_cnt;
  logic [WW-1:0]       r_rx_cnt;

  logic                w_start;
  logic                w_start_owner_d;
  logic                w_rx;
  logic                w_rx_last;
  logic [ADDR_W-1:0]   w_miss_addr;
  logic [WW-1:0]       w_issue_word;
  logic [WW-1:0]       w_rx_word;

  logic [15:0]         r_fill_data_p1;
  logic [WW-1:0]       r_fill_word_p1;
  logic                r_i_fill_vld_p1;
  logic                r_d_fill_vld_p1;
  logic                r_i_tag_vld_p1;
  logic                r_d_tag_vld_p1;

  // D has priority over I when both miss on the same edge.
  assign w_miss_addr = d_miss ? d_miss_addr : i_miss_addr;
  assign w_rx_last   = (r_rx_cnt == LAST);

`ifdef CRITICAL_WORD_FIRST_EN
  logic [WW-1:0] r_crit;
  logic          r_i_crit_vld_p1;
  logic          r_d_crit_vld_p1;

  // Block size is a power of two, so WW-bit addition wraps around the block.
  assign w_issue_word = r_crit + r_issue_cnt;
  assign w_rx_word    = r_crit + r_rx_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_crit          <= '0;
      r_i_crit_vld_p1 <= 1'b0;
      r_d_crit_vld_p1 <= 1'b0;
    end else begin
      if (w_start) r_crit <= w_miss_addr[WW:1];
      r_i_crit_vld_p1 <= w_rx && !r_owner_d && (r_rx_cnt == '0);
      r_d_crit_vld_p1 <= w_rx &&  r_owner_d && (r_rx_cnt == '0);
    end
  end

  assign i_crit_valid = r_i_crit_vld_p1;
  assign d_crit_valid = r_d_crit_vld_p1;
`else
  assign w_issue_word = r_issue_cnt;
  assign w_rx_word    = r_rx_cnt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_start         = 1'b0;
    w_start_owner_d = 1'b0;
    w_rx            = 1'b0;
    mem_en          = 1'b0;
    mem_wr          = 1'b0;
    mem_addr        = '0;
    mem_wdata       = '0;
    d_wr_ack        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (d_wr) begin
          w_state_nxt = S_WSTORE;
        end else if (d_miss || i_miss) begin
          w_start         = 1'b1;
          w_start_owner_d = d_miss;
          w_state_nxt     = S_ISSUE;
        end
      end
      S_WSTORE: begin
        // The store request is held until this ack, so the live inputs are stable.
        mem_en      = 1'b1;
        mem_wr      = 1'b1;
        mem_addr    = d_wr_addr & ~ADDR_W'(1);
        mem_wdata   = d_wr_data;
        d_wr_ack    = 1'b1;
        w_state_nxt = S_IDLE;
      end
      S_ISSUE: begin
        mem_en   = 1'b1;
        mem_addr = r_base | ADDR_W'({w_issue_word, 1'b0});
        w_rx     = mem_rvalid;
        if (r_issue_cnt == LAST) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        w_rx = mem_rvalid;
        if (w_rx && w_rx_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        // One quiet cycle lets the served cache drop its miss before re-arbitration.
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner_d   <= 1'b0;
      r_base      <= '0;
      r_issue_cnt <= '0;
      r_rx_cnt    <= '0;
    end else begin
      if (w_start) begin
        r_owner_d   <= w_start_owner_d;
        r_base      <= w_miss_addr & ~LOW_MASK;
        r_issue_cnt <= '0;
        r_rx_cnt    <= '0;
      end
      if (r_state == S_ISSUE) r_issue_cnt <= r_issue_cnt + WW'(1);
      if (w_rx)               r_rx_cnt    <= r_rx_cnt + WW'(1);
    end
  end

  // ---- stage p1: registered return word and its write strobes ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fill_data_p1  <= '0;
      r_fill_word_p1  <= '0;
      r_i_fill_vld_p1 <= 1'b0;
      r_d_fill_vld_p1 <= 1'b0;
      r_i_tag_vld_p1  <= 1'b0;
      r_d_tag_vld_p1  <= 1'b0;
    end else begin
      if (w_rx) begin
        r_fill_data_p1 <= mem_rdata;
        r_fill_word_p1 <= w_rx_word;
      end
      r_i_fill_vld_p1 <= w_rx && !r_owner_d;
      r_d_fill_vld_p1 <= w_rx &&  r_owner_d;
      r_i_tag_vld_p1  <= w_rx && !r_owner_d && w_rx_last;
      r_d_tag_vld_p1  <= w_rx &&  r_owner_d && w_rx_last;
    end
  end

  assign fill_data = r_fill_data_p1;
  assign fill_word = r_fill_word_p1;
  assign i_fill_we = r_i_fill_vld_p1;
  assign d_fill_we = r_d_fill_vld_p1;
  assign i_tag_we  = r_i_tag_vld_p1;
  assign d_tag_we  = r_d_tag_vld_p1;

  assign i_busy = (r_state inside {S_ISSUE, S_DRAIN, S_DONE}) && !r_owner_d;
  assign d_busy = (r_state inside {S_ISSUE, S_DRAIN, S_DONE}) &&  r_owner_d;

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Testbench for cache_fill_arbiter: directed scenarios plus randomized
// traffic, compared each cycle against a transaction-timeline model.
module tb_cache_fill_arbiter;
  localparam int BW = 8;
  localparam int AW = 16;
  localparam int WW = $clog2(BW);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_miss = 1'b0, d_miss = 1'b0, d_wr = 1'b0;
  logic [AW-1:0] i_miss_addr = '0, d_miss_addr = '0, d_wr_addr = '0;
  logic [15:0]   d_wr_data = '0;
  logic          d_wr_ack, mem_en, mem_wr;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wdata;
  logic [15:0]   mem_rdata = '0;
  logic          mem_rvalid = 1'b0;
  logic [15:0]   fill_data;
  logic [WW-1:0] fill_word;
  logic          i_fill_we, d_fill_we, i_tag_we, d_tag_we, i_busy, d_busy;
  logic          i_crit_valid, d_crit_valid;
`ifdef CRITICAL_WORD_FIRST_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
  assign i_crit_valid = 1'b0;
  assign d_crit_valid = 1'b0;
`endif

  always #5 clk = ~clk;

  cache_fill_arbiter #(.BLOCK_WORDS(BW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_miss(i_miss), .i_miss_addr(i_miss_addr),
    .d_miss(d_miss), .d_miss_addr(d_miss_addr),
    .d_wr(d_wr), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data), .d_wr_ack(d_wr_ack),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .fill_data(fill_data), .fill_word(fill_word),
    .i_fill_we(i_fill_we), .d_fill_we(d_fill_we),
    .i_tag_we(i_tag_we), .d_tag_we(d_tag_we),
`ifdef CRITICAL_WORD_FIRST_EN
    .i_crit_valid(i_crit_valid), .d_crit_valid(d_crit_valid),
`endif
    .i_busy(i_busy), .d_busy(d_busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lat = 4;
  logic [15:0] salt = 16'h5A3C;
  bit rand_en = 1'b0;

  // memory: in-order return queue
  int          q_due[$];
  logic [15:0] q_addr[$];

  // model: transaction currently occupying the arbiter (0 none, 1 store, 2 fill)
  int          m_kind = 0;
  int          m_start = 0;
  bit          m_own_d = 1'b0;
  logic [15:0] m_base = '0, m_saddr = '0, m_sdata = '0;
  int          m_crit = 0;

  // cache-side handshake flags and statistics
  bit saw_i_tag = 0, saw_d_tag = 0, saw_ack = 0;
  int cnt_ifill, cnt_dfill, cnt_itag, cnt_dtag, cnt_ack;
  int first_i_issue, first_d_issue, itag_cyc, dtag_cyc, first_fword;
  logic [15:0] first_raddr, last_wdata;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] memword(input logic [15:0] a);
    return (a * 16'h9E37) ^ salt;
  endfunction

  task automatic clr_stats();
    cnt_ifill = 0; cnt_dfill = 0; cnt_itag = 0; cnt_dtag = 0; cnt_ack = 0;
    first_i_issue = -1; first_d_issue = -1; itag_cyc = -1; dtag_cyc = -1;
    first_fword = -1; first_raddr = '0; last_wdata = '0;
  endtask

  // Decide what the arbiter does from the next edge on.
  task automatic model_advance();
    logic [15:0] a;
    if (!rst_n) begin m_kind = 0; return; end
    case (m_kind)
      0: begin
        if (d_wr) begin
          m_kind = 1; m_start = cyc + 1;
          m_saddr = d_wr_addr & 16'hFFFE; m_sdata = d_wr_data;
        end else if (d_miss || i_miss) begin
          m_kind = 2; m_start = cyc + 1; m_own_d = d_miss;
          a = d_miss ? d_miss_addr : i_miss_addr;
          m_base = a & ~16'(2 * BW - 1);
          m_crit = CWF ? int'((a >> 1) % BW) : 0;
        end
      end
      1: m_kind = 0;
      default: if (cyc - m_start == BW + lat) m_kind = 0;
    endcase
  endtask

  task automatic check_cycle();
    logic e_en, e_wr, e_ack, e_ib, e_db, e_ifw, e_dfw, e_itg, e_dtg, e_ic, e_dc;
    logic [15:0] e_addr;
    bit addr_v, fill_v;
    int rel, j, efw;
    {e_en, e_wr, e_ack, e_ib, e_db, e_ifw, e_dfw, e_itg, e_dtg, e_ic, e_dc} = '0;
    e_addr = '0; addr_v = 0; fill_v = 0; efw = 0;
    if (m_kind == 1) begin
      e_en = 1; e_wr = 1; e_ack = 1; e_addr = m_saddr; addr_v = 1;
    end else if (m_kind == 2) begin
      rel = cyc - m_start;
      if (rel < BW) begin
        e_en = 1; e_addr = m_base + 16'(2 * ((m_crit + rel) % BW)); addr_v = 1;
      end
      e_ib = !m_own_d; e_db = m_own_d;
      j = rel - lat - 1;
      if (j >= 0 && j < BW) begin
        fill_v = 1; efw = (m_crit + j) % BW;
        e_ifw = !m_own_d; e_dfw = m_own_d;
        e_itg = !m_own_d && (j == BW - 1); e_dtg = m_own_d && (j == BW - 1);
        e_ic = CWF && !m_own_d && (j == 0); e_dc = CWF && m_own_d && (j == 0);
      end
    end
    chk("ctrl", {mem_en, mem_wr, d_wr_ack, i_busy, d_busy, i_fill_we, d_fill_we,
                 i_tag_we, d_tag_we, i_crit_valid, d_crit_valid},
                {e_en, e_wr, e_ack, e_ib, e_db, e_ifw, e_dfw, e_itg, e_dtg, e_ic, e_dc});
    if (addr_v) chk("mem_addr", mem_addr, e_addr);
    if (m_kind == 1) chk("mem_wdata", mem_wdata, m_sdata);
    if (fill_v) begin
      chk("fill_word", fill_word, efw);
      chk("fill_data", fill_data, memword(m_base + 16'(2 * efw)));
    end
    // memory capture and statistics come from the DUT's observed behaviour
    if (mem_en && !mem_wr) begin
      q_due.push_back(cyc + lat); q_addr.push_back(mem_addr);
      if (first_i_issue < 0 && first_d_issue < 0) first_raddr = mem_addr;
      if (i_busy && first_i_issue < 0) first_i_issue = cyc;
      if (d_busy && first_d_issue < 0) first_d_issue = cyc;
    end
    if ((i_fill_we || d_fill_we) && first_fword < 0) first_fword = fill_word;
    cnt_ifill += int'(i_fill_we); cnt_dfill += int'(d_fill_we);
    cnt_itag  += int'(i_tag_we);  cnt_dtag  += int'(d_tag_we);
    if (i_tag_we) itag_cyc = cyc;
    if (d_tag_we) dtag_cyc = cyc;
    if (d_wr_ack) begin cnt_ack++; last_wdata = mem_wdata; end
    saw_i_tag = i_tag_we; saw_d_tag = d_tag_we; saw_ack = d_wr_ack;
  endtask

  task automatic step();
    bit dropped_i, dropped_d, dropped_w;
    model_advance();
    @(posedge clk); #1;
    cyc++;
    if (q_due.size() > 0 && q_due[0] == cyc) begin
      mem_rvalid = 1'b1; mem_rdata = memword(q_addr[0]);
      void'(q_due.pop_front()); void'(q_addr.pop_front());
    end else begin
      mem_rvalid = 1'b0; mem_rdata = 16'($urandom);
    end
    dropped_i = saw_i_tag; dropped_d = saw_d_tag; dropped_w = saw_ack;
    if (saw_i_tag) i_miss = 1'b0;
    if (saw_d_tag) d_miss = 1'b0;
    if (saw_ack)   d_wr = 1'b0;
    saw_i_tag = 0; saw_d_tag = 0; saw_ack = 0;
    if (rand_en) begin
      if (!i_miss && !dropped_i && $urandom_range(0, 3) == 0) begin
        i_miss = 1'b1; i_miss_addr = 16'($urandom);
      end
      if (!d_miss && !dropped_d && $urandom_range(0, 4) == 0) begin
        d_miss = 1'b1; d_miss_addr = 16'($urandom);
      end
      if (!d_wr && !dropped_w && $urandom_range(0, 5) == 0) begin
        d_wr = 1'b1; d_wr_addr = 16'($urandom) & 16'hFFFE; d_wr_data = 16'($urandom);
      end
    end
    @(negedge clk);
    check_cycle();
  endtask

  task automatic do_reset(input int ncyc, input int new_lat);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async", {mem_en, mem_wr, mem_addr, mem_wdata, d_wr_ack, fill_data, fill_word,
                      i_fill_we, d_fill_we, i_tag_we, d_tag_we, i_busy, d_busy,
                      i_crit_valid, d_crit_valid}, 64'd0);
    q_due.delete(); q_addr.delete();
    mem_rvalid = 1'b0; m_kind = 0;
    saw_i_tag = 0; saw_d_tag = 0; saw_ack = 0;
    lat = new_lat;
    repeat (ncyc) step();
    rst_n = 1'b1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((m_kind != 0 || i_miss || d_miss || d_wr) && n < 400) begin
      step(); n++;
    end
    chk("wait_idle_bound", n < 400, 1'b1);
    step();
  endtask

  initial begin
    clr_stats();
    #1;
    chk("rst_init", {mem_en, mem_wr, mem_addr, d_wr_ack, i_fill_we, d_fill_we,
                     i_tag_we, d_tag_we, i_busy, d_busy}, 64'd0);
    repeat (2) step();
    rst_n = 1'b1;
    step();

    // single I miss, latency 4
    clr_stats();
    i_miss = 1'b1; i_miss_addr = 16'h0036;
    wait_idle();
    chk("t2_first_addr", first_raddr, CWF ? 16'h0036 : 16'h0030);
    chk("t2_ifill_cnt", cnt_ifill, 8);
    chk("t2_itag_cnt", cnt_itag, 1);
    chk("t2_tag_lat", itag_cyc - first_i_issue, BW + 4);

    // simultaneous I and D misses: D first, I after D's DONE and one IDLE
    clr_stats();
    i_miss = 1'b1; i_miss_addr = 16'h0040;
    d_miss = 1'b1; d_miss_addr = 16'h2000;
    wait_idle();
    chk("t3_d_first", dtag_cyc < itag_cyc, 1'b1);
    chk("t3_i_start", first_i_issue - dtag_cyc, 2);
    chk("t3_fill_cnt", cnt_ifill + cnt_dfill, 2 * BW);

    // store beats a same-edge I miss
    clr_stats();
    d_wr = 1'b1; d_wr_addr = 16'h1234; d_wr_data = 16'hBEEF;
    i_miss = 1'b1; i_miss_addr = 16'h0080;
    wait_idle();
    chk("t4_ack_cnt", cnt_ack, 1);
    chk("t4_wdata", last_wdata, 16'hBEEF);
    chk("t4_itag_cnt", cnt_itag, 1);

    // reset after three D returns: fill aborted, then refilled in full
    clr_stats();
    d_miss = 1'b1; d_miss_addr = 16'h3010;
    begin
      int n = 0;
      while (cnt_dfill < 3 && n < 100) begin step(); n++; end
      chk("t5_reach_bound", n < 100, 1'b1);
    end
    do_reset(2, 4);
    chk("t5_no_tag", cnt_dtag, 0);
    clr_stats();
    wait_idle();
    chk("t5_refill_cnt", cnt_dfill, BW);
    chk("t5_refill_tag", cnt_dtag, 1);

`ifdef CRITICAL_WORD_FIRST_EN
    clr_stats();
    d_miss = 1'b1; d_miss_addr = 16'h100A;
    wait_idle();
    chk("t6_first_addr", first_raddr, 16'h100A);
    chk("t6_first_word", first_fword, 5);
`endif

    // randomized traffic at several memory latencies
    foreach (q_due[k]) q_due[k] = q_due[k];
    for (int li = 0; li < 4; li++) begin
      int lats[4] = '{1, 2, 3, 6};
      do_reset(2, lats[li]);
      salt = 16'($urandom);
      rand_en = 1'b1;
      repeat (250) step();
      rand_en = 1'b0;
      wait_idle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
